// File: rtl/i2s_clkgen.sv
// I2S/TDM bit and frame clock generator running from MCLK.
// Frame start/stop is aligned to frame boundaries; strobes lead edges by one MCLK.
module i2s_clkgen #(
  parameter int SLOTS = 2,
  parameter int SLOT_BITS = 32,
  parameter int DIV_W = 8,
  localparam int SI_W = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int BI_W = $clog2(SLOT_BITS)
) (
  input  logic             MCLK,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] half_div,
  input  logic             i2s_mode,
  output logic             SCLK,
  output logic             LRCLK,
  output logic [SI_W-1:0]  slot_idx,
  output logic [BI_W-1:0]  bit_idx,
  output logic             active,
  output logic             next_sclk_rise,
  output logic             next_sclk_fall,
  output logic             next_lrclk_rise,
  output logic             next_lrclk_fall,
  output logic             next_frame
);

  localparam int N = SLOTS * SLOT_BITS;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_act;
  logic             mode_act;

  logic bit_last;
  logic p_last;
  logic tick0;
  logic lr_nxt;
  logic stop_now;
  int   p_cur;
  int   p_nxt;

  // I2S framing reports the word select of the following bit period
  function automatic logic lr_of(input int q, input logic m);
    int q1;
    q1 = m ? ((q == N - 1) ? 0 : q + 1) : q;
    return q1 >= N / 2;
  endfunction

  assign active   = state != IDLE;
  assign bit_last = bit_idx == BI_W'(SLOT_BITS - 1);
  assign p_last   = bit_last && (slot_idx == SI_W'(SLOTS - 1));
  assign p_cur    = int'(slot_idx) * SLOT_BITS + int'(bit_idx);
  assign p_nxt    = p_last ? 0 : p_cur + 1;
  assign lr_nxt   = lr_of(p_nxt, mode_act);
  assign tick0    = active && (div_cnt == '0);

  assign next_sclk_rise  = tick0 && !SCLK;
  assign next_sclk_fall  = tick0 && SCLK;
  assign stop_now        = next_sclk_fall && p_last && !enable;
  assign next_lrclk_rise = next_sclk_fall && !stop_now && lr_nxt && !LRCLK;
  assign next_lrclk_fall = next_sclk_fall && !stop_now && !lr_nxt && LRCLK;
  assign next_frame      = next_sclk_fall && p_last && enable;

  always_ff @(posedge MCLK or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      div_act  <= '0;
      mode_act <= 1'b0;
      SCLK     <= 1'b0;
      LRCLK    <= 1'b0;
      slot_idx <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state    <= RUN;
            div_act  <= half_div;
            mode_act <= i2s_mode;
            div_cnt  <= half_div;
          end
        end
        default: begin
          if (stop_now) begin
            state    <= IDLE;
            div_cnt  <= '0;
            SCLK     <= 1'b0;
            LRCLK    <= 1'b0;
            slot_idx <= '0;
            bit_idx  <= '0;
          end else begin
            state <= enable ? RUN : STOP;
            if (div_cnt != '0) begin
              div_cnt <= div_cnt - DIV_W'(1);
            end else if (!SCLK) begin
              SCLK    <= 1'b1;
              div_cnt <= div_act;
            end else begin
              SCLK    <= 1'b0;
              LRCLK   <= lr_nxt;
              bit_idx <= bit_last ? '0 : bit_idx + BI_W'(1);
              if (bit_last)
                slot_idx <= p_last ? '0 : slot_idx + SI_W'(1);
              // frame boundary: pick up the new ratio and framing
              if (p_last) begin
                div_act  <= half_div;
                mode_act <= i2s_mode;
                div_cnt  <= half_div;
              end else begin
                div_cnt <= div_act;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_clkgen.sv
// Directed bench for i2s_clkgen: default 2x32 instance plus a 4x8 instance.
// Edge times are counted in MCLK edges after the enabling edge.
module tb_i2s_clkgen;

  logic       MCLK;
  logic       reset_n;
  logic       enable;
  logic [7:0] half_div;
  logic       i2s_mode;
  logic       sclk, lrclk, active;
  logic [0:0] slot_idx;
  logic [4:0] bit_idx;
  logic       nsr, nsf, nlr, nlf, nf;

  logic       en_b;
  logic [7:0] hd_b;
  logic       mode_b;
  logic       sclk_b, lrclk_b, active_b;
  logic [1:0] slot_b;
  logic [2:0] bit_b;
  logic       nsr_b, nsf_b, nlr_b, nlf_b, nf_b;

  i2s_clkgen u_dut (
    .MCLK(MCLK), .reset_n(reset_n), .enable(enable),
    .half_div(half_div), .i2s_mode(i2s_mode),
    .SCLK(sclk), .LRCLK(lrclk), .slot_idx(slot_idx),
    .bit_idx(bit_idx), .active(active),
    .next_sclk_rise(nsr), .next_sclk_fall(nsf),
    .next_lrclk_rise(nlr), .next_lrclk_fall(nlf),
    .next_frame(nf)
  );

  i2s_clkgen #(.SLOTS(4), .SLOT_BITS(8)) u_dut_b (
    .MCLK(MCLK), .reset_n(reset_n), .enable(en_b),
    .half_div(hd_b), .i2s_mode(mode_b),
    .SCLK(sclk_b), .LRCLK(lrclk_b), .slot_idx(slot_b),
    .bit_idx(bit_b), .active(active_b),
    .next_sclk_rise(nsr_b), .next_sclk_fall(nsf_b),
    .next_lrclk_rise(nlr_b), .next_lrclk_fall(nlf_b),
    .next_frame(nf_b)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int strobe_bad = 0;
  int alt_bad = 0;
  int first_rise, r_last, r_prev, lr_rise, lr_fall, nf1, nf2, nf_cnt;
  logic p_rst, p_sclk, p_lr, p_act, p_nsr, p_nsf, p_nlr, p_nlf, p_nf;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic start_rec();
    cyc = 0;
    first_rise = -1; r_last = -1; r_prev = -1;
    lr_rise = -1; lr_fall = -1;
    nf1 = -1; nf2 = -1; nf_cnt = 0;
  endtask

  // advance one MCLK edge, sample, and audit strobes of the default instance
  task automatic tick();
    @(posedge MCLK);
    #1;
    cyc++;
    if (reset_n && p_rst) begin
      if (p_nsr != (sclk && !p_sclk)) strobe_bad++;
      if (p_nsf != (!sclk && p_sclk)) strobe_bad++;
      if (active || !p_act) begin
        if (p_nlr != (lrclk && !p_lr)) strobe_bad++;
        if (p_nlf != (!lrclk && p_lr)) strobe_bad++;
      end
      if (p_nf && !(active && slot_idx == 0 && bit_idx == 0))
        strobe_bad++;
    end
    if (sclk && !p_sclk) begin
      r_prev = r_last;
      r_last = cyc;
      if (first_rise < 0) first_rise = cyc;
    end
    if (lrclk && !p_lr && lr_rise < 0) lr_rise = cyc;
    if (!lrclk && p_lr && lr_fall < 0) lr_fall = cyc;
    if (nf) begin
      nf_cnt++;
      if (nf1 < 0) nf1 = cyc;
      else if (nf2 < 0) nf2 = cyc;
    end
    p_rst = reset_n; p_sclk = sclk; p_lr = lrclk; p_act = active;
    p_nsr = nsr; p_nsf = nsf; p_nlr = nlr; p_nlf = nlf; p_nf = nf;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  // asynchronous reset asserted between edges; outputs must clear at once
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    enable = 1'b0;
    #2;
    check(tag, {sclk, lrclk, active, slot_idx, bit_idx,
                nsr, nsf, nlr, nlf, nf}, 0);
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; half_div = 8'd3; i2s_mode = 1'b0;
    en_b = 1'b0; hd_b = 8'd0; mode_b = 1'b0;
    p_rst = 0; p_sclk = 0; p_lr = 0; p_act = 0;
    p_nsr = 0; p_nsf = 0; p_nlr = 0; p_nlf = 0; p_nf = 0;
    start_rec();
    tick(); tick(); tick();
    check("rst_a", {sclk, lrclk, active, slot_idx, bit_idx,
                    nsr, nsf, nlr, nlf, nf}, 0);
    check("rst_b", {sclk_b, lrclk_b, active_b, slot_b, bit_b,
                    nsr_b, nsf_b, nlr_b, nlf_b, nf_b}, 0);
    reset_n = 1'b1;
    tick();
    check("idle_act", active, 0);

    // left-justified, half_div=3
    enable = 1'b1;
    tick();
    start_rec();
    check("lj_act", active, 1);
    check("lj_sclk0", sclk, 0);
    run_to(1030);
    check("lj_rise1", first_rise, 4);
    check("lj_period", r_last - r_prev, 8);
    check("lj_lr_rise", lr_rise, 256);
    check("lj_lr_fall", lr_fall, 512);
    check("lj_nf1", nf1, 511);
    check("lj_nf2", nf2, 1023);

    // I2S framing leads LJ by one SCLK period
    do_reset("rst_i2s");
    i2s_mode = 1'b1;
    enable = 1'b1;
    tick();
    start_rec();
    run_to(520);
    check("i2s_rise1", first_rise, 4);
    check("i2s_lr_rise", lr_rise, 248);
    check("i2s_lr_fall", lr_fall, 504);

    // ratio change mid-frame takes effect at the frame boundary
    do_reset("rst_div");
    i2s_mode = 1'b0;
    half_div = 8'd3;
    enable = 1'b1;
    tick();
    start_rec();
    run_to(100);
    half_div = 8'd1;
    run_to(511);
    check("div_old_last", r_last, 508);
    check("div_old_prev", r_prev, 500);
    run_to(518);
    check("div_new_first", r_prev, 514);
    check("div_new_next", r_last, 518);
    run_to(770);
    check("div_nf1", nf1, 511);
    check("div_nf2", nf2, 767);

    // stop request at p=10 finishes the frame
    do_reset("rst_stop");
    half_div = 8'd3;
    enable = 1'b1;
    tick();
    start_rec();
    run_to(84);
    enable = 1'b0;
    while (active && cyc < 1200) tick();
    check("stop_idle_at", cyc, 512);
    check("stop_clk", {sclk, lrclk}, 0);
    check("stop_pos", {slot_idx, bit_idx}, 0);
    check("stop_nf", nf_cnt, 0);
    check("stop_last_rise", r_last, 508);

    // stop then re-enable inside the frame: no gap
    enable = 1'b1;
    tick();
    start_rec();
    run_to(84);
    enable = 1'b0;
    run_to(324);
    enable = 1'b1;
    run_to(1030);
    check("reen_act", active, 1);
    check("reen_nf1", nf1, 511);
    check("reen_nf2", nf2, 1023);
    check("reen_last", r_last, 1028);
    check("reen_prev", r_prev, 1020);

    // mid-frame async reset, then clean restart
    do_reset("rst_mid");
    enable = 1'b1;
    tick();
    start_rec();
    run_to(9);
    check("rst_rise1", first_rise, 4);
    check("rst_pos", {slot_idx, bit_idx}, 1);

    // 4 slots x 8 bits, half_div=0
    en_b = 1'b1;
    tick();
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (nsr_b == nsf_b || nsr_b != !sclk_b) alt_bad++;
      if (i == 1)  check("b_sclk1", sclk_b, 1);
      if (i == 15) check("b_slot15", slot_b, 0);
      if (i == 16) check("b_slot16", slot_b, 1);
      if (i == 31) check("b_31", {lrclk_b, slot_b}, 3'b001);
      if (i == 32) check("b_32", {lrclk_b, slot_b}, 3'b110);
      if (i == 48) check("b_48", {lrclk_b, slot_b}, 3'b111);
      if (i == 63) check("b_63", {nf_b, lrclk_b, slot_b}, 4'b1111);
      if (i == 64) check("b_64", {nf_b, lrclk_b, slot_b}, 4'b0000);
    end
    check("b_alt", alt_bad, 0);
    check("a_strobes", strobe_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
